// File: rtl/wb_merge.sv
// wb_merge: writeback merge stage in front of the register-file write port.
//
// Arbitrates between never-stalling ALU results and handshaked load responses.
// Loads that cannot issue directly wait in a small in-order buffer. One
// registered register-file write is produced per cycle.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   alu_valid/addr/data/ppp    ALU result (no backpressure)
//   ld_valid/ready/addr/data/ppp  load response, valid/ready handshake
//   wr_en/addr/data/ppp        registered register-file write
//   pend_mask                  registers targeted by buffered loads (bit 0 never set)
//   buf_count                  number of buffered loads
//   ppp_err                    sticky flag: an illegal PPP code was dropped
module wb_merge #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BUF_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [0:DATA_WIDTH-1]        alu_data,
    input  logic [2:0]                   alu_ppp,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_WIDTH-1:0]        ld_addr,
    input  logic [0:DATA_WIDTH-1]        ld_data,
    input  logic [2:0]                   ld_ppp,
    output logic                         wr_en,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [0:DATA_WIDTH-1]        wr_data,
    output logic [2:0]                   wr_ppp,
    output logic [DEPTH-1:0]             pend_mask,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic                         ppp_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Load buffer storage; only bufValid needs a reset value.
    logic [ADDR_WIDTH-1:0] bufAddr [BUF_DEPTH];
    logic [0:DATA_WIDTH-1] bufData [BUF_DEPTH];
    logic [2:0]            bufPpp  [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]  bufValid;
    logic [PTR_W-1:0]      headPtr;
    logic [PTR_W-1:0]      tailPtr;
    logic [CNT_W-1:0]      bufCount;

    logic                  ldAccept;
    logic                  selValid;
    logic                  selDirect;
    logic                  deq;
    logic                  enq;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [0:DATA_WIDTH-1] selData;
    logic [2:0]            selPpp;
    logic                  selIllegal;

    // ld_ready depends only on registered state so it cannot form a loop.
    assign ld_ready  = !reset && (bufCount < CNT_W'(BUF_DEPTH));
    assign ldAccept  = ld_valid && ld_ready;
    assign buf_count = bufCount;

    // Priority: ALU, then buffer head, then a directly accepted load.
    always_comb begin
        selValid  = 1'b0;
        selDirect = 1'b0;
        deq       = 1'b0;
        selAddr   = '0;
        selData   = '0;
        selPpp    = '0;
        if (alu_valid) begin
            selValid = 1'b1;
            selAddr  = alu_addr;
            selData  = alu_data;
            selPpp   = alu_ppp;
        end else if (bufCount != '0) begin
            selValid = 1'b1;
            deq      = 1'b1;
            selAddr  = bufAddr[headPtr];
            selData  = bufData[headPtr];
            selPpp   = bufPpp[headPtr];
        end else if (ldAccept) begin
            selValid  = 1'b1;
            selDirect = 1'b1;
            selAddr   = ld_addr;
            selData   = ld_data;
            selPpp    = ld_ppp;
        end
    end

    assign enq        = ldAccept && !selDirect;
    assign selIllegal = selPpp > 3'd4;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (bufValid[i]) begin
                pend_mask[bufAddr[i]] = 1'b1;
            end
        end
        // R0 is read-only, so a load to it is never a hazard.
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            bufAddr[tailPtr] <= ld_addr;
            bufData[tailPtr] <= ld_data;
            bufPpp[tailPtr]  <= ld_ppp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bufValid <= '0;
            headPtr  <= '0;
            tailPtr  <= '0;
            bufCount <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_ppp   <= 3'b000;
            ppp_err  <= 1'b0;
        end else begin
            // Head and tail only coincide when empty (no deq) or full (no enq).
            if (deq) begin
                bufValid[headPtr] <= 1'b0;
                headPtr           <= headPtr + PTR_W'(1);
            end
            if (enq) begin
                bufValid[tailPtr] <= 1'b1;
                tailPtr           <= tailPtr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   bufCount <= bufCount + CNT_W'(1);
                2'b01:   bufCount <= bufCount - CNT_W'(1);
                default: bufCount <= bufCount;
            endcase

            wr_en <= 1'b0;
            if (selValid) begin
                if (selIllegal) begin
                    ppp_err <= 1'b1;
                end else if (selAddr != '0) begin
                    wr_en   <= 1'b1;
                    wr_addr <= selAddr;
                    wr_data <= selData;
                    wr_ppp  <= selPpp;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_merge.sv
module tb_wb_merge;

    localparam int DW = 64;
    localparam int NREG = 32;
    localparam int AW = 5;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [0:DW-1] alu_data;
    logic [2:0]    alu_ppp;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [0:DW-1] ld_data;
    logic [2:0]    ld_ppp;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [0:DW-1] wr_data;
    logic [2:0]    wr_ppp;
    logic [NREG-1:0] pend_mask;
    logic [1:0]    buf_count;
    logic          ppp_err;

    always #5 clk = ~clk;

    wb_merge #(
        .DATA_WIDTH(DW),
        .DEPTH(NREG),
        .ADDR_WIDTH(AW),
        .BUF_DEPTH(BD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .alu_ppp(alu_ppp),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .ld_ppp(ld_ppp),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ppp(wr_ppp),
        .pend_mask(pend_mask),
        .buf_count(buf_count),
        .ppp_err(ppp_err)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    p;
    } entry_t;

    // Reference model: a FIFO of waiting loads plus the expected write port.
    entry_t        mq[$];
    logic          mEn;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    logic [2:0]    mPpp;
    logic          mErr;

    int nAsserts = 0;
    int nFails   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] modelMask();
        logic [NREG-1:0] m = '0;
        foreach (mq[i]) m[mq[i].a] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic checkAll(input string tag);
        check({tag, ".wr_en"}, 64'(wr_en), 64'(mEn));
        if (mEn) begin
            check({tag, ".wr_addr"}, 64'(wr_addr), 64'(mAddr));
            check({tag, ".wr_data"}, wr_data, mData);
            check({tag, ".wr_ppp"}, 64'(wr_ppp), 64'(mPpp));
        end
        check({tag, ".buf_count"}, 64'(buf_count), 64'(mq.size()));
        check({tag, ".pend_mask"}, 64'(pend_mask), 64'(modelMask()));
        check({tag, ".ppp_err"}, 64'(ppp_err), 64'(mErr));
    endtask

    task automatic idleInputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0; alu_ppp = '0;
        ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0; ld_ppp  = '0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b1;
        @(posedge clk); #1;
        mq.delete();
        mEn = 1'b0; mAddr = '0; mData = '0; mPpp = '0; mErr = 1'b0;
        check("rst.ld_ready", 64'(ld_ready), 64'd0);
        check("rst.wr_addr", 64'(wr_addr), 64'd0);
        check("rst.wr_data", wr_data, 64'd0);
        check("rst.wr_ppp", 64'(wr_ppp), 64'd0);
        checkAll("rst");
        reset = 1'b0;
        #1;
        check("rst.ld_ready_after", 64'(ld_ready), 64'd1);
    endtask

    // One clock with the given inputs; model predicts, then everything is checked.
    task automatic cycle(input string tag,
                         input logic av, input logic [AW-1:0] aa, input logic [63:0] ad,
                         input logic [2:0] ap,
                         input logic lv, input logic [AW-1:0] la, input logic [63:0] ldd,
                         input logic [2:0] lp);
        bit     ready, accept, haveSel;
        entry_t sel, ld;
        alu_valid = av; alu_addr = aa; alu_data = ad; alu_ppp = ap;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd; ld_ppp  = lp;
        ready  = mq.size() < BD;
        accept = lv && ready;
        check({tag, ".ld_ready"}, 64'(ld_ready), 64'(ready));
        ld.a = la; ld.d = ldd; ld.p = lp;
        haveSel = 1'b1;
        if (av) begin
            sel.a = aa; sel.d = ad; sel.p = ap;
            if (accept) mq.push_back(ld);
        end else if (mq.size() > 0) begin
            sel = mq.pop_front();
            if (accept) mq.push_back(ld);
        end else if (accept) begin
            sel = ld;
        end else begin
            haveSel = 1'b0;
        end
        mEn = 1'b0;
        if (haveSel) begin
            if (sel.p > 3'd4) mErr = 1'b1;
            else if (sel.a != 0) begin
                mEn = 1'b1; mAddr = sel.a; mData = sel.d; mPpp = sel.p;
            end
        end
        @(posedge clk); #1;
        checkAll(tag);
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        doReset();

        // Single ALU write.
        cycle("alu1", 1, 5'd5, 64'h0123456789ABCDEF, 3'b000, 0, 0, 0, 0);
        check("alu1.en", 64'(wr_en), 64'd1);
        check("alu1.addr", 64'(wr_addr), 64'd5);
        check("alu1.data", wr_data, 64'h0123456789ABCDEF);
        cycle("idle1", 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU busy for three cycles while loads to 7 and 9 arrive.
        cycle("busy1", 1, 5'd1, 64'h11, 3'b000, 1, 5'd7, 64'h7777, 3'b001);
        check("busy1.count", 64'(buf_count), 64'd1);
        cycle("busy2", 1, 5'd2, 64'h22, 3'b000, 1, 5'd9, 64'h9999, 3'b010);
        check("busy2.count", 64'(buf_count), 64'd2);
        check("busy2.ready", 64'(ld_ready), 64'd0);
        check("busy2.mask", 64'(pend_mask), 64'h280);
        cycle("busy3", 1, 5'd3, 64'h33, 3'b000, 1, 5'd11, 64'hBBBB, 3'b000);
        cycle("drain1", 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain1.addr", 64'(wr_addr), 64'd7);
        cycle("drain2", 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain2.addr", 64'(wr_addr), 64'd9);
        check("drain2.count", 64'(buf_count), 64'd0);

        // Hold one entry buffered, then stream loads: simultaneous enq/deq and wrap.
        cycle("wrap0", 1, 5'd4, 64'h44, 3'b000, 1, 5'd12, 64'hC0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            cycle("wrap", 0, 0, 0, 0, 1, AW'(13 + i), 64'hD0 + 64'(i), 3'b011);
            check("wrap.count", 64'(buf_count), 64'd1);
            check("wrap.addr", 64'(wr_addr), 64'(12 + i));
        end
        cycle("wrapEnd", 0, 0, 0, 0, 0, 0, 0, 0);
        check("wrapEnd.addr", 64'(wr_addr), 64'd17);

        // Load to R0 and illegal PPP from the ALU.
        cycle("r0", 0, 0, 0, 0, 1, 5'd0, 64'hDEAD, 3'b000);
        check("r0.en", 64'(wr_en), 64'd0);
        cycle("bad", 1, 5'd6, 64'hBEEF, 3'b110, 0, 0, 0, 0);
        check("bad.en", 64'(wr_en), 64'd0);
        check("bad.err", 64'(ppp_err), 64'd1);
        cycle("badHold", 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with two loads buffered.
        cycle("fill1", 1, 5'd8, 64'h88, 3'b000, 1, 5'd20, 64'h2020, 3'b000);
        cycle("fill2", 1, 5'd8, 64'h89, 3'b000, 1, 5'd21, 64'h2121, 3'b000);
        check("fill2.count", 64'(buf_count), 64'd2);
        doReset();
        for (int i = 0; i < 3; i++) cycle("postRst", 0, 0, 0, 0, 0, 0, 0, 0);

        // Direct load in e mode.
        cycle("direct", 0, 0, 0, 0, 1, 5'd10, 64'hA5A5, 3'b011);
        check("direct.ppp", 64'(wr_ppp), 64'd3);
        check("direct.count", 64'(buf_count), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [63:0] rd1, rd2;
            rd1 = {$urandom, $urandom};
            rd2 = {$urandom, $urandom};
            cycle("rand",
                  ($urandom_range(0, 9) < 4), AW'($urandom_range(0, 31)), rd1,
                  3'($urandom_range(0, 5)),
                  ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 31)), rd2,
                  3'($urandom_range(0, 5)));
            if (i == 200) doReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
